// File: rtl/branch_pred_ctrl.sv
// Branch predictor and redirect controller: direct-mapped BTB with 2-bit counters,
// combinational lookup on the fetch PC, mispredict/flush detection and training from EX.
module branch_pred_ctrl #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        prediction,
    output logic [31:0] control_pc,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred,
    input  logic [31:0] ex_pred_pc,
    output logic        flush,
    output logic [31:0] pc_branch,
    output logic [31:0] br_cnt,
    output logic [31:0] mis_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr        [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             res;
    logic             mispredict;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // Lookup reads the arrays directly, so a same-cycle write is seen only after the edge.
    assign if_hit = valid[if_idx] && (tag_mem[if_idx] == if_tag);
    assign ex_hit = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);

    assign res        = ex_valid && ex_is_branch;
    assign mispredict = res && ((ex_taken != ex_pred) ||
                                (ex_taken && ex_pred && (ex_pred_pc != ex_target)));

    assign flush      = !rst && mispredict;
    assign pc_branch  = (rst || !res) ? 32'd0 : (ex_taken ? ex_target : ex_pc + 32'd4);

    // Flush owns the fetch redirect, so a taken prediction is suppressed under it.
    assign prediction = if_hit && ctr[if_idx][1] && !flush;
    assign control_pc = if_hit ? target_mem[if_idx] : if_pc + 32'd4;

    // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            br_cnt  <= '0;
            mis_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b00;
            end
        end else if (res) begin
            br_cnt <= br_cnt + 32'd1;
            if (mispredict) begin
                mis_cnt <= mis_cnt + 32'd1;
            end
            if (ex_hit) begin
                if (ex_taken && ctr[ex_idx] != 2'b11) begin
                    ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
                end else if (!ex_taken && ctr[ex_idx] != 2'b00) begin
                    ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid[ex_idx] <= 1'b1;
                ctr[ex_idx]   <= 2'b10;
            end
        end
    end

    // NOTE: tag/target storage has no reset; the valid bits alone make stale contents harmless.
    // Any taken resolve writes both: on a hit the tag is unchanged, on a miss it allocates.
    always_ff @(posedge clk) begin
        if (!rst && res && ex_taken) begin
            tag_mem[ex_idx]    <= ex_tag;
            target_mem[ex_idx] <= ex_target;
        end
    end

endmodule
